load_store_queue: RTL and testbench

LOAD_STORE_QUEUE -- requirements
Module: load_store_queue

---
 rtl/load_store_queue_if.sv | 56 +++++
 rtl/load_store_queue.sv | 144 ++++++++++++++
 tb/tb_load_store_queue.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_queue_if.sv
// Shared types for the load/store queue and its dispatch/AGU/ROB/memory bus.
package rv32i_types;
  localparam int unsigned ROB_ID_SIZE = 4;

  typedef enum logic [1:0] {
    mem_idle    = 2'b00,
    mem_wait_rd = 2'b01,
    mem_wait_wr = 2'b10,
    mem_done    = 2'b11
  } mem_state_t;

  typedef struct packed {
    logic                   valid;
    logic [31:0]            dmem_addr;
    logic [3:0]             dmem_rmask;
    logic [3:0]             dmem_wmask;
    logic [31:0]            dmem_wdata;
    logic [2:0]             funct3;
    logic [ROB_ID_SIZE-1:0] rob_id;
  } ls_mem_bus_t;
endpackage

// Dispatch, AGU, ROB-head, memory-response and memory-request signals of the LSQ.
interface load_store_queue_if #(
  parameter int unsigned ROB_BITS = rv32i_types::ROB_ID_SIZE
);
  logic                      alloc_valid;
  logic                      alloc_ready;
  logic [ROB_BITS-1:0]       alloc_rob_id;
  logic [2:0]                alloc_funct3;
  logic                      alloc_is_store;
  logic                      agu_valid;
  logic [ROB_BITS-1:0]       agu_rob_id;
  logic [31:0]               agu_addr;
  logic [31:0]               agu_wdata;
  logic                      rob_head_valid;
  logic [ROB_BITS-1:0]       rob_head_id;
  logic [1:0]                mem_state;
  logic                      resp_valid;
  logic [ROB_BITS-1:0]       resp_rob_id;
  rv32i_types::ls_mem_bus_t  mem_out;

  modport master (
    output alloc_valid, alloc_rob_id, alloc_funct3, alloc_is_store,
    output agu_valid, agu_rob_id, agu_addr, agu_wdata,
    output rob_head_valid, rob_head_id, mem_state, resp_valid, resp_rob_id,
    input  alloc_ready, mem_out
  );

  modport slave (
    input  alloc_valid, alloc_rob_id, alloc_funct3, alloc_is_store,
    input  agu_valid, agu_rob_id, agu_addr, agu_wdata,
    input  rob_head_valid, rob_head_id, mem_state, resp_valid, resp_rob_id,
    output alloc_ready, mem_out
  );
endinterface

// File: rtl/load_store_queue.sv
// In-order circular load/store queue: allocates at dispatch, captures AGU
// results, issues the head to memory one request at a time and pops on response.
// Optional macro LSQ_EARLY_LOAD_EN lets loads at the head issue without
// waiting to become the ROB head; stores always wait.
module load_store_queue
  import rv32i_types::*;
#(
  parameter int unsigned DEPTH_BITS = 3,
  parameter int unsigned ROB_BITS   = ROB_ID_SIZE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_branch_mispredict,
  load_store_queue_if.slave     lsq,
  output logic [DEPTH_BITS:0]   o_count
);

  localparam int unsigned       DEPTH     = 2 ** DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] DEPTH_CNT = (DEPTH_BITS + 1)'(DEPTH);

  logic [DEPTH-1:0]      r_valid;
  logic [DEPTH-1:0]      r_ready;
  logic [DEPTH-1:0]      r_is_store;
  logic [ROB_BITS-1:0]   r_rob_id [DEPTH];
  logic [2:0]            r_funct3 [DEPTH];
  logic [31:0]           r_addr   [DEPTH];
  logic [31:0]           r_wdata  [DEPTH];
  logic [DEPTH_BITS-1:0] r_head;
  logic [DEPTH_BITS-1:0] r_tail;
  logic [DEPTH_BITS:0]   r_count;
  logic                  r_inflight;
  logic                  r_alloc_ready;
  ls_mem_bus_t           r_mem_out;

  logic                  w_alloc;
  logic                  w_head_match;
  logic                  w_rob_ok;
  logic                  w_issue;
  logic                  w_pop;
  logic [ROB_BITS-1:0]   w_head_rob;
  logic [31:0]           w_head_addr;
  logic [3:0]            w_mask;
  logic [DEPTH_BITS:0]   w_count_nxt;
  ls_mem_bus_t           w_mem_bus;

  // Handshakes and head eligibility, all from registered queue state.
  always_comb begin
    w_alloc      = lsq.alloc_valid && r_alloc_ready;
    w_head_rob   = r_rob_id[r_head];
    w_head_addr  = r_addr[r_head];
    w_head_match = lsq.rob_head_valid && (lsq.rob_head_id == w_head_rob);
`ifdef LSQ_EARLY_LOAD_EN
    w_rob_ok     = !r_is_store[r_head] || w_head_match;
`else
    w_rob_ok     = w_head_match;
`endif
    w_issue      = r_valid[r_head] && r_ready[r_head] && !r_inflight &&
                   (lsq.mem_state == mem_idle) && w_rob_ok;
    w_pop        = r_inflight && lsq.resp_valid && (lsq.resp_rob_id == w_head_rob);
    case ({w_alloc, w_pop})
      2'b10:   w_count_nxt = r_count + (DEPTH_BITS + 1)'(1);
      2'b01:   w_count_nxt = r_count - (DEPTH_BITS + 1)'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Memory request built from the head entry: byte-lane mask and lane-aligned data.
  always_comb begin
    w_mask = 4'b0000;
    case (r_funct3[r_head])
      3'b000, 3'b100: w_mask = 4'b0001 << w_head_addr[1:0];
      3'b001, 3'b101: w_mask = 4'b0011 << {w_head_addr[1], 1'b0};
      3'b010:         w_mask = 4'b1111;
      default:        w_mask = 4'b0000;
    endcase
    w_mem_bus            = '0;
    w_mem_bus.valid      = 1'b1;
    w_mem_bus.dmem_addr  = w_head_addr;
    w_mem_bus.dmem_rmask = r_is_store[r_head] ? 4'b0000 : w_mask;
    w_mem_bus.dmem_wmask = r_is_store[r_head] ? w_mask : 4'b0000;
    w_mem_bus.dmem_wdata = r_wdata[r_head] << {w_head_addr[1:0], 3'b000};
    w_mem_bus.funct3     = r_funct3[r_head];
    w_mem_bus.rob_id     = ROB_ID_SIZE'(w_head_rob);
  end

  // Control state: valid/ready bits, pointers, count, in-flight flag, outputs.
  always_ff @(posedge clk) begin
    if (rst || i_branch_mispredict) begin
      r_valid       <= '0;
      r_ready       <= '0;
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_inflight    <= 1'b0;
      r_alloc_ready <= 1'b1;
      r_mem_out     <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (lsq.agu_valid && r_valid[i] && (r_rob_id[i] == lsq.agu_rob_id)) begin
          r_ready[i] <= 1'b1;
        end
      end
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_ready[r_tail] <= 1'b0;
        r_tail          <= r_tail + DEPTH_BITS'(1);
      end
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + DEPTH_BITS'(1);
      end
      if (w_issue) begin
        r_inflight <= 1'b1;
      end else if (w_pop) begin
        r_inflight <= 1'b0;
      end
      r_count       <= w_count_nxt;
      r_alloc_ready <= (w_count_nxt < DEPTH_CNT);
      r_mem_out     <= w_issue ? w_mem_bus : '0;
    end
  end

  // Entry payload: identity on allocation, address/data on AGU match.
  always_ff @(posedge clk) begin
    if (!rst && !i_branch_mispredict) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (lsq.agu_valid && r_valid[i] && (r_rob_id[i] == lsq.agu_rob_id)) begin
          r_addr[i]  <= lsq.agu_addr;
          r_wdata[i] <= lsq.agu_wdata;
        end
      end
      if (w_alloc) begin
        r_rob_id[r_tail]   <= lsq.alloc_rob_id;
        r_funct3[r_tail]   <= lsq.alloc_funct3;
        r_is_store[r_tail] <= lsq.alloc_is_store;
      end
    end
  end

  assign lsq.alloc_ready = r_alloc_ready;
  assign lsq.mem_out     = r_mem_out;
  assign o_count         = r_count;

endmodule

// File: tb/tb_load_store_queue.sv
// Randomized and directed bench for load_store_queue against a queue-based reference model.
module tb_load_store_queue;
  import rv32i_types::*;

  localparam int DEPTH = 8;

  typedef struct {
    logic [3:0]  rob;
    logic [2:0]  f3;
    bit          st;
    bit          rdy;
    logic [31:0] addr;
    logic [31:0] wdata;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [3:0] o_count;

  load_store_queue_if #(.ROB_BITS(4)) lsq_bus ();

  load_store_queue #(.DEPTH_BITS(3), .ROB_BITS(4)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_branch_mispredict (flush),
    .lsq                 (lsq_bus),
    .o_count             (o_count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errs   = 0;
  ent_t        q[$];
  bit          inflight = 0;
  bit          last_acc;
  int          pops = 0;
  int          exp_count;
  bit          exp_ready;
  ls_mem_bus_t exp_mo;
  logic [3:0]  next_rob = 4'd0;

`ifdef LSQ_EARLY_LOAD_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit roll(input int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  // Memory request the head entry should produce, from byte size and offset.
  function automatic ls_mem_bus_t bus_of(input ent_t e);
    ls_mem_bus_t b;
    int nb, off;
    logic [3:0] m;
    off = int'(e.addr % 4);
    case (e.f3)
      3'd0, 3'd4: nb = 1;
      3'd1, 3'd5: begin nb = 2; off = off - (off % 2); end
      3'd2:       begin nb = 4; off = 0; end
      default:    nb = 0;
    endcase
    m = 4'(((1 << nb) - 1) << off);
    b = '0;
    b.valid      = 1'b1;
    b.dmem_addr  = e.addr;
    b.dmem_rmask = e.st ? 4'b0 : m;
    b.dmem_wmask = e.st ? m : 4'b0;
    b.dmem_wdata = 32'(e.wdata << (8 * (e.addr % 4)));
    b.funct3     = e.f3;
    b.rob_id     = e.rob;
    return b;
  endfunction

  // Advance the reference model by one clock using the currently driven inputs.
  task automatic model_step();
    ls_mem_bus_t mo;
    bit elig, pop, head_ok;
    int n;
    ent_t e;
    mo = '0;
    last_acc = 0;
    n = q.size();
    if (rst || flush) begin
      q.delete();
      inflight = 0;
    end else begin
      last_acc = lsq_bus.alloc_valid && (n < DEPTH);
      elig = 0;
      if (n > 0 && q[0].rdy && !inflight && lsq_bus.mem_state == 2'd0) begin
        head_ok = lsq_bus.rob_head_valid && (lsq_bus.rob_head_id == q[0].rob);
        if (EARLY && !q[0].st) head_ok = 1;
        elig = head_ok;
      end
      if (elig) mo = bus_of(q[0]);
      pop = inflight && n > 0 && lsq_bus.resp_valid && (lsq_bus.resp_rob_id == q[0].rob);
      foreach (q[i]) begin
        if (lsq_bus.agu_valid && q[i].rob == lsq_bus.agu_rob_id) begin
          q[i].rdy = 1; q[i].addr = lsq_bus.agu_addr; q[i].wdata = lsq_bus.agu_wdata;
        end
      end
      if (pop) begin void'(q.pop_front()); inflight = 0; pops++; end
      if (elig) inflight = 1;
      if (last_acc) begin
        e.rob = lsq_bus.alloc_rob_id; e.f3 = lsq_bus.alloc_funct3; e.st = lsq_bus.alloc_is_store;
        e.rdy = 0; e.addr = '0; e.wdata = '0;
        q.push_back(e);
      end
    end
    exp_mo    = mo;
    exp_count = q.size();
    exp_ready = q.size() < DEPTH;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_val("count", 128'(o_count), 128'(exp_count));
    check_val("alloc_ready", 128'(lsq_bus.alloc_ready), 128'(exp_ready));
    check_val("mem_out", 128'(lsq_bus.mem_out), 128'(exp_mo));
  endtask

  task automatic idle_inputs();
    rst = 0; flush = 0;
    lsq_bus.alloc_valid = 0; lsq_bus.alloc_rob_id = '0; lsq_bus.alloc_funct3 = '0;
    lsq_bus.alloc_is_store = 0; lsq_bus.agu_valid = 0; lsq_bus.agu_rob_id = '0;
    lsq_bus.agu_addr = '0; lsq_bus.agu_wdata = '0; lsq_bus.rob_head_valid = 0;
    lsq_bus.rob_head_id = '0; lsq_bus.mem_state = 2'd0; lsq_bus.resp_valid = 0;
    lsq_bus.resp_rob_id = '0;
  endtask

  task automatic alloc_op(input logic [3:0] rob, input logic [2:0] f3, input bit st);
    idle_inputs();
    lsq_bus.alloc_valid = 1; lsq_bus.alloc_rob_id = rob;
    lsq_bus.alloc_funct3 = f3; lsq_bus.alloc_is_store = st;
    tick();
  endtask

  task automatic agu_op(input logic [3:0] rob, input logic [31:0] addr, input logic [31:0] wd);
    idle_inputs();
    lsq_bus.agu_valid = 1; lsq_bus.agu_rob_id = rob;
    lsq_bus.agu_addr = addr; lsq_bus.agu_wdata = wd;
    tick();
  endtask

  // One randomized cycle; arguments are percent probabilities.
  task automatic drive_cycle(input int pa, input int pg, input int ph, input int pi,
                             input int pr, input int pf, input int prst);
    int cand[$];
    idle_inputs();
    lsq_bus.alloc_valid    = roll(pa);
    lsq_bus.alloc_rob_id   = next_rob;
    lsq_bus.alloc_funct3   = 3'($urandom_range(0, 7));
    lsq_bus.alloc_is_store = 1'($urandom_range(0, 1));
    foreach (q[i]) if (!q[i].rdy) cand.push_back(i);
    if (cand.size() > 0 && roll(pg)) begin
      lsq_bus.agu_valid  = 1;
      lsq_bus.agu_rob_id = q[cand[$urandom_range(0, cand.size() - 1)]].rob;
    end else if (roll(10)) begin
      lsq_bus.agu_valid  = 1;
      lsq_bus.agu_rob_id = 4'($urandom_range(0, 15));
    end
    lsq_bus.agu_addr  = $urandom;
    lsq_bus.agu_wdata = $urandom;
    if (q.size() > 0 && roll(ph)) begin
      lsq_bus.rob_head_valid = 1; lsq_bus.rob_head_id = q[0].rob;
    end else begin
      lsq_bus.rob_head_valid = 1'($urandom_range(0, 1));
      lsq_bus.rob_head_id    = 4'($urandom_range(0, 15));
    end
    lsq_bus.mem_state = roll(pi) ? 2'd0 : 2'($urandom_range(1, 3));
    if (inflight && q.size() > 0 && roll(pr)) begin
      lsq_bus.resp_valid = 1; lsq_bus.resp_rob_id = q[0].rob;
    end else if (roll(10)) begin
      lsq_bus.resp_valid = 1; lsq_bus.resp_rob_id = 4'($urandom_range(0, 15));
    end
    flush = roll(pf);
    rst   = roll(prst);
    tick();
    if (last_acc) next_rob = next_rob + 4'd1;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    tick();
    check_val("rst_ready", 128'(lsq_bus.alloc_ready), 128'(1));

    // Fill all eight slots, then a ninth request must be refused.
    for (int i = 0; i < 8; i++) alloc_op(4'(i), 3'd2, 0);
    check_val("full_count", 128'(o_count), 128'(8));
    check_val("full_ready", 128'(lsq_bus.alloc_ready), 128'(0));
    alloc_op(4'd9, 3'd2, 0);
    check_val("ninth_refused", 128'(o_count), 128'(8));
    idle_inputs(); flush = 1; tick();

    // Byte load at offset 3.
    alloc_op(4'd5, 3'd0, 0);
    agu_op(4'd5, 32'h0000_1003, 32'h0);
    idle_inputs(); lsq_bus.rob_head_valid = 1; lsq_bus.rob_head_id = 4'd5; tick();
    check_val("lb_valid", 128'(lsq_bus.mem_out.valid), 128'(1));
    check_val("lb_rmask", 128'(lsq_bus.mem_out.dmem_rmask), 128'(4'b1000));
    check_val("lb_wmask", 128'(lsq_bus.mem_out.dmem_wmask), 128'(0));
    check_val("lb_addr", 128'(lsq_bus.mem_out.dmem_addr), 128'(32'h1003));
    tick();
    check_val("lb_one_pulse", 128'(lsq_bus.mem_out.valid), 128'(0));
    lsq_bus.resp_valid = 1; lsq_bus.resp_rob_id = 4'd5; tick();

    // Halfword store at offset 2, then its response pops it.
    alloc_op(4'd2, 3'd1, 1);
    agu_op(4'd2, 32'h0000_2002, 32'h0000_ABCD);
    idle_inputs(); lsq_bus.rob_head_valid = 1; lsq_bus.rob_head_id = 4'd2; tick();
    check_val("sh_wmask", 128'(lsq_bus.mem_out.dmem_wmask), 128'(4'b1100));
    check_val("sh_wdata", 128'(lsq_bus.mem_out.dmem_wdata), 128'(32'hABCD_0000));
    check_val("sh_rmask", 128'(lsq_bus.mem_out.dmem_rmask), 128'(0));
    tick();
    check_val("sh_before_resp", 128'(o_count), 128'(1));
    lsq_bus.resp_valid = 1; lsq_bus.resp_rob_id = 4'd2; tick();
    check_val("sh_popped", 128'(o_count), 128'(0));

    // Load ready at the head while the ROB head is a different op.
    alloc_op(4'd7, 3'd2, 0);
    agu_op(4'd7, 32'h0000_3000, 32'h0);
    idle_inputs(); lsq_bus.rob_head_valid = 1; lsq_bus.rob_head_id = 4'd6; tick();
    check_val("early_load", 128'(lsq_bus.mem_out.valid), 128'(EARLY));
    idle_inputs(); flush = 1; tick();

    // Flush while a request is in flight with four entries queued.
    for (int i = 0; i < 4; i++) alloc_op(4'(i), 3'd2, 0);
    for (int i = 0; i < 4; i++) begin
      agu_op(4'(i), 32'h100 + 32'(4 * i), 32'h0);
      lsq_bus.rob_head_valid = 1; lsq_bus.rob_head_id = 4'd0;
    end
    idle_inputs(); lsq_bus.rob_head_valid = 1; lsq_bus.rob_head_id = 4'd0; tick();
    check_val("pre_flush_inflight", 128'(inflight), 128'(1));
    idle_inputs(); flush = 1; tick();
    check_val("flush_count", 128'(o_count), 128'(0));
    check_val("flush_ready", 128'(lsq_bus.alloc_ready), 128'(1));
    for (int i = 0; i < 4; i++) begin
      idle_inputs(); lsq_bus.rob_head_valid = 1; lsq_bus.rob_head_id = 4'(i); tick();
      check_val("flush_no_issue", 128'(lsq_bus.mem_out.valid), 128'(0));
    end

    // Full queue churn: continuous pops and allocations so the pointers wrap.
    next_rob = 4'd0;
    for (int i = 0; i < 8; i++) drive_cycle(100, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) drive_cycle(0, 100, 0, 0, 0, 0, 0);
    pops = 0;
    for (int i = 0; i < 60; i++) drive_cycle(100, 100, 100, 100, 100, 0, 0);
    check_val("wrap_pops_ge10", 128'(pops >= 10), 128'(1));

    // Free-running random traffic including occasional flush and reset.
    for (int i = 0; i < 3000; i++) drive_cycle(60, 50, 75, 70, 50, 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
    $finish;
  end

endmodule
